fixed_self_attention_key_transpose_buffer: RTL

Sits directly downstream of the key projection output of the QKV input block and feeds the QK^T matmul. It captures one complete streamed K matrix, tile by tile, into an on-chip buffer. It then replays that matrix as transposed tiles (K^T), REPEAT times, one pass per query row-block streamed by the matmul. Its counterpart on the query path is the existing query latency-matching FIFO.

---
 rtl/fixed_self_attention_key_transpose_buffer_pkg.sv | 34 +++
 rtl/fixed_self_attention_key_transpose_buffer_tile_ram.sv | 44 ++++
 rtl/fixed_self_attention_key_transpose_buffer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_self_attention_key_transpose_buffer_pkg.sv
// ---------------------------------------------------------------------------
// fixed_self_attention_key_transpose_buffer_pkg
//
// Shared definitions for the key transpose buffer:
//   - state_t           : buffer phase, FILL (capturing K) or DRAIN (replaying K^T)
//   - D0/D1/TILES/ADDR_W: tile geometry for the default 64x20 K matrix, 4x4 tiles
//   - cnt_width()       : counter width for a given range, never below 1 bit
//   - transpose_src_index(): which input element feeds a given transposed element
// ---------------------------------------------------------------------------
package fixed_self_attention_key_transpose_buffer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int D0     = 64 / 4;
    localparam int D1     = 20 / 4;
    localparam int TILES  = D0 * D1;
    localparam int ADDR_W = (TILES > 1) ? $clog2(TILES) : 1;

    // Width of a counter that must hold 0..range-1; a range of 1 still
    // gets a single bit so that the counter is a real signal.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

    // Output tile element k = j*p1 + i carries input element i*p0 + j,
    // so the row index i is k mod p1 and the column index j is k div p1.
    function automatic int transpose_src_index(input int out_idx, input int p0, input int p1);
        return (out_idx % p1) * p0 + (out_idx / p1);
    endfunction

endpackage

// File: rtl/fixed_self_attention_key_transpose_buffer_tile_ram.sv
// ---------------------------------------------------------------------------
// key_transpose_tile_ram
//
// Simple dual-port RAM holding one whole K matrix as DEPTH tiles of WIDTH
// bits. One write port, one read port with a registered (1-cycle) read.
// Contents are not reset.
//
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write tile address
//   wr_data  : tile to write
//   rd_en    : read strobe, rd_data updates on the next edge only when set
//   rd_addr  : read tile address
//   rd_data  : registered read data
// ---------------------------------------------------------------------------
module key_transpose_tile_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Fill and drain never overlap, so there is no read/write collision to
    // arbitrate; the read register simply holds when no read is issued.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fixed_self_attention_key_transpose_buffer.sv
// ---------------------------------------------------------------------------
// fixed_self_attention_key_transpose_buffer
//
// Captures one streamed K matrix (row-major tiles) into a tile RAM, then
// replays it REPEAT times as transposed tiles (K^T) in column-major tile
// order for the QK^T matmul.
//
// Ports:
//   clk            : clock
//   rst            : asynchronous reset, active low
//   data_in        : K tile, element i*P0+j = tile row i, col j
//   data_in_valid  : input handshake valid
//   data_in_ready  : input handshake ready (high only while filling)
//   data_out       : K^T tile, element j*P1+i = input element i*P0+j
//   data_out_valid : output handshake valid
//   data_out_ready : output handshake ready
//   data_out_last  : marks the final tile of each replay pass
// ---------------------------------------------------------------------------
module fixed_self_attention_key_transpose_buffer
    import fixed_self_attention_key_transpose_buffer_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int TENSOR_SIZE_DIM_0 = 64,
    parameter int TENSOR_SIZE_DIM_1 = 20,
    parameter int PARALLELISM_DIM_0 = 4,
    parameter int PARALLELISM_DIM_1 = 4,
    parameter int REPEAT            = TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic [DATA_WIDTH*PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0]     data_in,
    input  logic                                                          data_in_valid,
    output logic                                                          data_in_ready,
    output logic [DATA_WIDTH*PARALLELISM_DIM_1*PARALLELISM_DIM_0-1:0]     data_out,
    output logic                                                          data_out_valid,
    input  logic                                                          data_out_ready,
    output logic                                                          data_out_last
);

    localparam int COL_TILES = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0;
    localparam int ROW_TILES = TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1;
    localparam int NUM_TILES = COL_TILES * ROW_TILES;
    localparam int ELEMS     = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int TILE_W    = DATA_WIDTH * ELEMS;
    localparam int AW        = cnt_width(NUM_TILES);
    localparam int RW        = cnt_width(ROW_TILES);
    localparam int CW        = cnt_width(COL_TILES);
    localparam int PW        = cnt_width(REPEAT);

    state_t            state;
    logic [AW-1:0]     wr_cnt;
    logic [RW-1:0]     r_cnt;
    logic [CW-1:0]     c_cnt;
    logic [PW-1:0]     pass_cnt;
    logic              reads_done;

    logic              in_fire;
    logic              out_fire;
    logic              issue_rd;
    logic              tile_last;
    logic              tile_final;
    logic [AW-1:0]     rd_addr;
    logic [2:0]        occ_next;
    logic [TILE_W-1:0] rd_data;
    logic [TILE_W-1:0] tile_t;

    logic              rd_valid_q;
    logic              rd_last_q;
    logic              rd_final_q;

    logic [TILE_W-1:0] skid_data [2];
    logic [1:0]        skid_last;
    logic [1:0]        skid_final;
    logic              skid_wp;
    logic              skid_rp;
    logic [1:0]        skid_cnt;

    assign in_fire  = data_in_valid & data_in_ready;
    assign out_fire = data_out_valid & data_out_ready;

    // Input tiles arrive row-major, so tile (r, c) lands at r*D0+c, which is
    // just the running tile count. Replay walks tile rows fastest.
    assign rd_addr    = AW'(int'(r_cnt) * COL_TILES + int'(c_cnt));
    assign tile_last  = (c_cnt == CW'(COL_TILES - 1)) && (r_cnt == RW'(ROW_TILES - 1));
    assign tile_final = tile_last && (pass_cnt == PW'(REPEAT - 1));

    // Tiles in flight are the RAM read stage plus the skid entries. A new
    // read is allowed when, after this cycle's pop, fewer than two are
    // outstanding, so the two skid entries can never overflow while a
    // continuously ready consumer still sees one tile per cycle.
    always_comb begin
        occ_next = {1'b0, skid_cnt} + {2'b00, rd_valid_q} - {2'b00, out_fire};
        issue_rd = (state == DRAIN) && !reads_done && (occ_next < 3'd2);
    end

    key_transpose_tile_ram #(
        .DEPTH (NUM_TILES),
        .WIDTH (TILE_W),
        .AW    (AW)
    ) u_tile_ram (
        .clk     (clk),
        .wr_en   (in_fire),
        .wr_addr (wr_cnt),
        .wr_data (data_in),
        .rd_en   (issue_rd),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Pure rewiring of the read tile into its transpose.
    always_comb begin
        tile_t = '0;
        for (int k = 0; k < ELEMS; k++) begin
            tile_t[k*DATA_WIDTH +: DATA_WIDTH] =
                rd_data[transpose_src_index(k, PARALLELISM_DIM_0, PARALLELISM_DIM_1)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Phase control: count written tiles during FILL, then walk the read
    // counters (row inner, column outer, pass outermost) during DRAIN. The
    // phase returns to FILL only when the very last replayed tile leaves the
    // output, not when it is read, so fill never overwrites pending data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FILL;
            wr_cnt        <= '0;
            r_cnt         <= '0;
            c_cnt         <= '0;
            pass_cnt      <= '0;
            reads_done    <= 1'b0;
            data_in_ready <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    data_in_ready <= 1'b1;
                    if (in_fire) begin
                        if (wr_cnt == AW'(NUM_TILES - 1)) begin
                            wr_cnt        <= '0;
                            r_cnt         <= '0;
                            c_cnt         <= '0;
                            pass_cnt      <= '0;
                            reads_done    <= 1'b0;
                            data_in_ready <= 1'b0;
                            state         <= DRAIN;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    data_in_ready <= 1'b0;
                    if (issue_rd) begin
                        if (r_cnt == RW'(ROW_TILES - 1)) begin
                            r_cnt <= '0;
                            if (c_cnt == CW'(COL_TILES - 1)) begin
                                c_cnt <= '0;
                                if (pass_cnt == PW'(REPEAT - 1)) begin
                                    pass_cnt   <= '0;
                                    reads_done <= 1'b1;
                                end else begin
                                    pass_cnt <= pass_cnt + 1'b1;
                                end
                            end else begin
                                c_cnt <= c_cnt + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (out_fire && skid_final[skid_rp]) begin
                        data_in_ready <= 1'b1;
                        state         <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Read stage valid and the last/final markers that travel alongside
    // the RAM read data into the skid buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_final_q <= 1'b0;
        end else begin
            rd_valid_q <= issue_rd;
            if (issue_rd) begin
                rd_last_q  <= tile_last;
                rd_final_q <= tile_final;
            end
        end
    end

    // Two-entry skid buffer control: every completed read is pushed, the
    // head entry is popped on an output handshake. The head only moves on a
    // pop, so data_out and data_out_last hold during backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_wp    <= 1'b0;
            skid_rp    <= 1'b0;
            skid_cnt   <= '0;
            skid_last  <= '0;
            skid_final <= '0;
        end else begin
            if (rd_valid_q) begin
                skid_last[skid_wp]  <= rd_last_q;
                skid_final[skid_wp] <= rd_final_q;
                skid_wp             <= ~skid_wp;
            end
            if (out_fire) begin
                skid_rp <= ~skid_rp;
            end
            case ({rd_valid_q, out_fire})
                2'b10:   skid_cnt <= skid_cnt + 1'b1;
                2'b01:   skid_cnt <= skid_cnt - 1'b1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    // Tile payload storage for the skid buffer; validity is tracked by the
    // count above, so the payload itself needs no reset.
    always_ff @(posedge clk) begin
        if (rd_valid_q) begin
            skid_data[skid_wp] <= tile_t;
        end
    end

    assign data_out       = skid_data[skid_rp];
    assign data_out_valid = (skid_cnt != 2'd0);
    assign data_out_last  = data_out_valid & skid_last[skid_rp];

endmodule
